// File: rtl/regbank_arbiter.sv
// Round-robin arbiter that sequences port A / port B accesses onto a bank of register cells.
// Each access walks ACCESS -> SETTLE -> DONE, giving at most one access every four cycles.
module regbank_arbiter #(
  parameter int DW    = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_wdata,
  output logic             a_gnt,
  output logic             a_done,
  output logic [DW-1:0]    a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_wdata,
  output logic             b_gnt,
  output logic             b_done,
  output logic [DW-1:0]    b_rdata,
  output logic [NREGS-1:0] reg_rs,
  output logic             reg_rw,
  output logic [DW-1:0]    reg_din,
  input  logic [DW-1:0]    reg_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state;
  logic          ptr;      // 0 = A has priority on a tie, 1 = B
  logic          op_port;  // 0 = A, 1 = B
  logic          op_we;
  logic          op_hit;   // address falls inside the bank
  logic          pick_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] addr);
    logic [NREGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign pick_b    = b_req & (~a_req | ptr);
  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      op_port <= 1'b0;
      op_we   <= 1'b0;
      op_hit  <= 1'b0;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      reg_rs  <= '0;
      reg_rw  <= 1'b0;
      reg_din <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            op_port <= pick_b;
            op_we   <= sel_we;
            op_hit  <= |onehot(sel_addr);
            a_gnt   <= ~pick_b;
            b_gnt   <= pick_b;
            reg_rs  <= onehot(sel_addr);
            reg_rw  <= sel_we;
            reg_din <= sel_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          a_gnt  <= 1'b0;
          b_gnt  <= 1'b0;
          reg_rw <= 1'b0;
          state  <= SETTLE;
        end
        SETTLE: begin
          // Out-of-range reads return zero instead of whatever the external mux shows.
          if (!op_we) begin
            if (op_port) b_rdata <= op_hit ? reg_dout : '0;
            else         a_rdata <= op_hit ? reg_dout : '0;
          end
          reg_rs <= '0;
          a_done <= ~op_port;
          b_done <= op_port;
          state  <= DONE;
        end
        DONE: begin
          a_done <= 1'b0;
          b_done <= 1'b0;
          ptr    <= ~op_port;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter (3-cell bank so address 3 is out of range): directed cases plus
// random traffic, compared every cycle against a transaction-phase model.
module tb_regbank_arbiter;

  localparam int DW    = 8;
  localparam int NREGS = 3;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_done, b_gnt, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [NREGS-1:0] reg_rs;
  logic          reg_rw;
  logic [DW-1:0] reg_din;
  logic [DW-1:0] reg_dout;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  regbank_arbiter #(.DW(DW), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .reg_rs(reg_rs), .reg_rw(reg_rw), .reg_din(reg_din), .reg_dout(reg_dout)
  );

  // Register cells driven by the DUT
  logic [DW-1:0] cells [NREGS] = '{default: 8'h00};

  always @(posedge clk) begin
    if (reg_rw) begin
      for (int i = 0; i < NREGS; i++) if (reg_rs[i]) cells[i] <= reg_din;
    end
  end

  always_comb begin
    reg_dout = 8'h00;
    for (int i = 0; i < NREGS; i++) if (reg_rs[i]) reg_dout = cells[i];
  end

  // Reference model: phase 0 idle, 1 access, 2 settle, 3 done
  int            ph = 0;
  logic          m_ptr = 1'b0;
  logic          m_win = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = 2'd0;
  logic [DW-1:0] m_din = 8'h00;
  logic [DW-1:0] m_ard = 8'h00;
  logic [DW-1:0] m_brd = 8'h00;
  logic [DW-1:0] m_cells [NREGS] = '{default: 8'h00};

  function automatic logic [NREGS-1:0] tb_oh(input logic [AW-1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0; m_ptr <= 1'b0; m_ard <= 8'h00; m_brd <= 8'h00; m_din <= 8'h00;
    end else begin
      case (ph)
        0: if (a_req || b_req) begin
          logic w;
          w = (a_req && b_req) ? m_ptr : b_req;
          m_win  <= w;
          m_we   <= w ? b_we : a_we;
          m_addr <= w ? b_addr : a_addr;
          m_din  <= w ? b_wdata : a_wdata;
          ph <= 1;
        end
        1: begin
          if (m_we && m_addr < 2'd3) m_cells[m_addr] <= m_din;
          ph <= 2;
        end
        2: begin
          if (!m_we) begin
            if (m_win) m_brd <= (m_addr < 2'd3) ? m_cells[m_addr] : 8'h00;
            else       m_ard <= (m_addr < 2'd3) ? m_cells[m_addr] : 8'h00;
          end
          ph <= 3;
        end
        default: begin
          m_ptr <= ~m_win;
          ph <= 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_gnt",   32'(a_gnt),   32'(ph == 1 && !m_win));
      check("b_gnt",   32'(b_gnt),   32'(ph == 1 && m_win));
      check("a_done",  32'(a_done),  32'(ph == 3 && !m_win));
      check("b_done",  32'(b_done),  32'(ph == 3 && m_win));
      check("reg_rs",  32'(reg_rs),  32'((ph == 1 || ph == 2) ? tb_oh(m_addr) : 3'b000));
      check("reg_rw",  32'(reg_rw),  32'(ph == 1 && m_we));
      check("reg_din", 32'(reg_din), 32'(m_din));
      check("a_rdata", 32'(a_rdata), 32'(m_ard));
      check("b_rdata", 32'(b_rdata), 32'(m_brd));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 2'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 8'h00;

    // 1. reset, then idle with no requests
    step(); chk_en = 1'b1;
    step();
    check("rst_outs", 32'({a_gnt, b_gnt, a_done, b_done, reg_rs, reg_rw}), 32'd0);
    check("rst_data", 32'({a_rdata, b_rdata, reg_din}), 32'd0);
    rst = 1'b0;
    step(); step();
    check("idle_rs", 32'(reg_rs), 32'd0);

    // 2. A writes FF to reg 2
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd2; a_wdata = 8'hFF;
    step();
    check("t2_gnt", 32'(a_gnt), 32'd1);
    check("t2_rs",  32'(reg_rs), 32'(3'b100));
    check("t2_rw",  32'(reg_rw), 32'd1);
    check("t2_din", 32'(reg_din), 32'hFF);
    a_req = 1'b0;
    step();
    check("t2_done_early", 32'(a_done), 32'd0);
    step();
    check("t2_done", 32'(a_done), 32'd1);
    check("t2_cell", 32'(cells[2]), 32'hFF);
    step();

    // 3. B reads reg 2
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd2;
    step();
    check("t3_gnt", 32'(b_gnt), 32'd1);
    b_req = 1'b0;
    step(); step();
    check("t3_done",  32'(b_done), 32'd1);
    check("t3_rdata", 32'(b_rdata), 32'hFF);
    check("t3_ardata", 32'(a_rdata), 32'h00);
    step();

    // 4. both request continuously: A,B,A,B four cycles apart
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd2;
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd1; b_wdata = 8'h5A;
    for (int c = 1; c <= 16; c++) begin
      logic [1:0] eg;
      step();
      eg = 2'b00;
      if (c % 4 == 1) eg = (((c - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      check("t4_gnt", 32'({a_gnt, b_gnt}), 32'(eg));
      if (c == 16) begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    step();
    check("t4_cell1", 32'(cells[1]), 32'h5A);

    // 5. A reads out-of-range address 3
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd3;
    step();
    check("t5_gnt", 32'(a_gnt), 32'd1);
    check("t5_rs0", 32'(reg_rs), 32'd0);
    a_req = 1'b0;
    step();
    check("t5_rs1", 32'(reg_rs), 32'd0);
    step();
    check("t5_done",  32'(a_done), 32'd1);
    check("t5_rdata", 32'(a_rdata), 32'h00);
    step();

    // 6. reset during SETTLE of a B read, then lone A request
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd1;
    step();
    check("t6_gnt", 32'(b_gnt), 32'd1);
    b_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t6_nodone", 32'(b_done), 32'd0);
    check("t6_outs", 32'({a_gnt, b_gnt, a_done, reg_rs, reg_rw}), 32'd0);
    check("t6_rdata", 32'(b_rdata), 32'h00);
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd0; a_wdata = 8'h33;
    step();
    check("t6_agnt", 32'(a_gnt), 32'd1);
    a_req = 1'b0;
    step(); step(); step();

    // Random traffic
    repeat (400) begin
      step();
      a_req = 1'($urandom_range(1, 0)); a_we = 1'($urandom_range(1, 0));
      a_addr = 2'($urandom_range(3, 0)); a_wdata = 8'($urandom_range(255, 0));
      b_req = 1'($urandom_range(1, 0)); b_we = 1'($urandom_range(1, 0));
      b_addr = 2'($urandom_range(3, 0)); b_wdata = 8'($urandom_range(255, 0));
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
